// File: rtl/conv_axi_full_wr_slave_if.sv
// AXI4 write-channel bundle (AW, W, B) for the s01 port of the convolution accelerator.
interface conv_axi_full_wr_slave_if #(
   parameter int ID_W   = 1,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      input  wdata, wstrb, wlast, wvalid, bready,
      output awready, wready, bid, bresp, bvalid
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      output wdata, wstrb, wlast, wvalid, bready,
      input  awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/conv_axi_full_wr_slave.sv
// AXI4 write slave: each accepted W beat becomes a one-cycle buffer word write (beat->mem_we 1 cycle).
// One burst at a time; AW stalls outside IDLE, W stalls outside DATA, B holds until bready.
module conv_axi_full_wr_slave #(
   parameter int C_S01_AXI_ID_WIDTH   = 1,
   parameter int C_S01_AXI_DATA_WIDTH = 32,
   parameter int C_S01_AXI_ADDR_WIDTH = 12,
   parameter int MEM_DEPTH            = 128
) (
   input  logic                              s01_axi_aclk,
   input  logic                              s01_axi_areset,
   conv_axi_full_wr_slave_if.slave           s01_axi,
   output logic                              mem_we,
   output logic [C_S01_AXI_ADDR_WIDTH-3:0]   mem_addr,
   output logic [C_S01_AXI_DATA_WIDTH-1:0]   mem_wdata,
   output logic [3:0]                        mem_be,
   output logic                              busy
);
   localparam int PTR_W = C_S01_AXI_ADDR_WIDTH - 2;
   localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(MEM_DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

   state_t                        state;
   logic [C_S01_AXI_ID_WIDTH-1:0] id_q;
   logic [PTR_W-1:0]              ptr;
   logic [7:0]                    len;
   logic [7:0]                    count;
   logic                          fixed;
   logic                          err;

   logic beat, in_range, last_cnt, burst_end, wrap_err, beat_err;
   logic unused_addr_lsb;

   assign unused_addr_lsb = ^s01_axi.awaddr[1:0];

   always_comb begin
      beat      = (state == DATA) && s01_axi.wvalid && s01_axi.wready;
      in_range  = {1'b0, ptr} < DEPTH;
      last_cnt  = (count == len);
      burst_end = last_cnt || s01_axi.wlast;
      wrap_err  = !fixed && (&ptr);
      // early wlast and missing wlast are both protocol errors
      beat_err  = !in_range || wrap_err || (last_cnt != s01_axi.wlast);
   end

   always_ff @(posedge s01_axi_aclk or posedge s01_axi_areset) begin
      if (s01_axi_areset) begin
         state           <= IDLE;
         id_q            <= '0;
         ptr             <= '0;
         len             <= '0;
         count           <= '0;
         fixed           <= 1'b0;
         err             <= 1'b0;
         s01_axi.awready <= 1'b0;
         s01_axi.wready  <= 1'b0;
         s01_axi.bvalid  <= 1'b0;
         s01_axi.bid     <= '0;
         s01_axi.bresp   <= 2'b00;
         mem_we          <= 1'b0;
         mem_addr        <= '0;
         mem_wdata       <= '0;
         mem_be          <= '0;
         busy            <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (s01_axi.awvalid && s01_axi.awready) begin
                  id_q            <= s01_axi.awid;
                  ptr             <= s01_axi.awaddr[C_S01_AXI_ADDR_WIDTH-1:2];
                  len             <= s01_axi.awlen;
                  fixed           <= (s01_axi.awburst == 2'b00);
                  count           <= '0;
                  err             <= (s01_axi.awsize != 3'b010) || s01_axi.awburst[1];
                  s01_axi.awready <= 1'b0;
                  s01_axi.wready  <= 1'b1;
                  busy            <= 1'b1;
                  state           <= DATA;
               end else begin
                  s01_axi.awready <= 1'b1;
               end
            end
            DATA: begin
               if (beat) begin
                  // errors raised by this beat only gate later beats
                  mem_we    <= !err && in_range;
                  mem_addr  <= ptr;
                  mem_wdata <= s01_axi.wdata;
                  mem_be    <= s01_axi.wstrb;
                  count     <= count + 8'd1;
                  if (!fixed) ptr <= ptr + PTR_W'(1);
                  if (beat_err) err <= 1'b1;
                  if (burst_end) begin
                     s01_axi.wready <= 1'b0;
                     s01_axi.bvalid <= 1'b1;
                     s01_axi.bid    <= id_q;
                     s01_axi.bresp  <= (err || beat_err) ? 2'b10 : 2'b00;
                     state          <= RESP;
                  end
               end
            end
            RESP: begin
               if (s01_axi.bready) begin
                  s01_axi.bvalid  <= 1'b0;
                  s01_axi.awready <= 1'b1;
                  busy            <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_axi_full_wr_slave.sv
// Bench for conv_axi_full_wr_slave: directed bursts plus random bursts against a burst-level model.
module tb_conv_axi_full_wr_slave;
   localparam int ID_W   = 1;
   localparam int ADDR_W = 12;
   localparam int DEPTH  = 128;
   localparam int PTR_W  = ADDR_W - 2;

   typedef struct packed {
      logic [PTR_W-1:0] addr;
      logic [31:0]      data;
      logic [3:0]       be;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conv_axi_full_wr_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(32)) axi ();

   logic             mem_we;
   logic [PTR_W-1:0] mem_addr;
   logic [31:0]      mem_wdata;
   logic [3:0]       mem_be;
   logic             busy;

   conv_axi_full_wr_slave #(
      .C_S01_AXI_ID_WIDTH  (ID_W),
      .C_S01_AXI_DATA_WIDTH(32),
      .C_S01_AXI_ADDR_WIDTH(ADDR_W),
      .MEM_DEPTH           (DEPTH)
   ) dut (
      .s01_axi_aclk  (clk),
      .s01_axi_areset(rst),
      .s01_axi       (axi.slave),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_be        (mem_be),
      .busy          (busy)
   );

   int  checks   = 0;
   int  failures = 0;
   int  cyc      = 0;
   bit  rand_gaps = 1'b0;
   wr_t got_q[$];
   int  got_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         got_q.push_back(wr_t'{mem_addr, mem_wdata, mem_be});
         got_cyc.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check_eq(tag, {axi.awready, axi.wready, axi.bvalid, axi.bresp, axi.bid,
                     mem_we, mem_addr, mem_wdata, mem_be, busy}, 64'd0);
   endtask

   // last_at: beat index carrying wlast, -1 for none
   task automatic run_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input int last_at, input int bready_wait, input bit directed);
      wr_t         exp_q[$];
      int          exp_beat[$];
      int          beat_cyc[$];
      logic [31:0] dat[$];
      logic [3:0]  stb[$];
      bit          err;
      bit          hs;
      int          ptr, n_beats, hc, gap, last_cyc;
      logic [1:0]  exp_resp;

      // reference: walk the beats with plain integer arithmetic
      err     = (size != 3'd2) || (burst == 2'd2) || (burst == 2'd3);
      ptr     = int'(addr) / 4;
      n_beats = 0;
      for (int i = 0; i <= int'(len); i++) begin
         dat.push_back(directed ? 32'h11 * (i + 1) : $urandom);
         stb.push_back(directed ? 4'hF : 4'($urandom));
         n_beats++;
         if (ptr >= DEPTH) err = 1'b1;
         else if (!err) begin
            exp_q.push_back(wr_t'{PTR_W'(ptr), dat[i], stb[i]});
            exp_beat.push_back(i);
         end
         if (burst == 2'd1) begin
            if (ptr == (1 << PTR_W) - 1) err = 1'b1;
            ptr = (ptr + 1) % (1 << PTR_W);
         end
         if (i == last_at && i < int'(len)) err = 1'b1;
         if (i == int'(len) && last_at != i) err = 1'b1;
         if (i == last_at) break;
      end
      exp_resp = err ? 2'b10 : 2'b00;

      got_q.delete();
      got_cyc.delete();
      @(posedge clk); #1;
      axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
      axi.awvalid = 1'b1;
      hs = 1'b0; hc = 0;
      for (int t = 0; t < 20 && !hs; t++) begin
         @(negedge clk); hs = axi.awready; hc = cyc;
         @(posedge clk); #1;
      end
      axi.awvalid = 1'b0;
      if (!hs) begin check_eq("aw_timeout", 0, 1); return; end
      @(negedge clk);
      check_eq("wready_lat", {axi.wready, axi.awready, busy}, 3'b101);
      @(posedge clk); #1;

      last_cyc = 0;
      for (int i = 0; i < n_beats; i++) begin
         axi.wvalid = 1'b0;
         gap = rand_gaps ? int'($urandom_range(0, 2)) : 0;
         repeat (gap) begin @(posedge clk); #1; end
         axi.wvalid = 1'b1; axi.wdata = dat[i]; axi.wstrb = stb[i]; axi.wlast = (i == last_at);
         hs = 1'b0;
         for (int t = 0; t < 20 && !hs; t++) begin
            @(negedge clk); hs = axi.wready; hc = cyc;
            @(posedge clk); #1;
         end
         if (!hs) begin check_eq("w_timeout", 0, 1); axi.wvalid = 1'b0; return; end
         beat_cyc.push_back(hc);
         last_cyc = hc;
      end
      axi.wvalid = 1'b0; axi.wlast = 1'b0;

      hs = 1'b0;
      for (int t = 0; t < 20 && !hs; t++) begin
         @(negedge clk); hs = axi.bvalid; hc = cyc;
      end
      if (!hs) begin check_eq("b_timeout", 0, 1); return; end
      check_eq("b_lat", hc, last_cyc + 1);
      check_eq("b_id", axi.bid, id);
      check_eq("b_resp", axi.bresp, exp_resp);
      check_eq("b_ready_lo", {axi.awready, axi.wready}, 2'b00);
      repeat (bready_wait) begin
         @(negedge clk);
         check_eq("b_hold", {axi.bvalid, axi.bid, axi.bresp, axi.awready},
                  {1'b1, id, exp_resp, 1'b0});
      end
      @(posedge clk); #1; axi.bready = 1'b1;
      @(posedge clk); #1; axi.bready = 1'b0;
      @(negedge clk);
      check_eq("idle_after_b", {axi.awready, axi.bvalid, busy}, 3'b100);

      check_eq("wr_count", got_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
         check_eq("wr_data", got_q[j], exp_q[j]);
         check_eq("wr_lat", got_cyc[j], beat_cyc[exp_beat[j]] + 1);
      end
   endtask

   initial begin
      logic [ADDR_W-1:0] a;
      logic [7:0]        l;
      logic [2:0]        sz;
      logic [1:0]        bt;
      int                r, la, beats;
      bit                hs;

      axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
      axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
      axi.wvalid = 1'b0; axi.bready = 1'b0;

      repeat (3) @(posedge clk);
      #1 check_idle("reset_state");
      @(negedge clk); rst = 1'b0;
      #1 check_eq("awready_at_release", axi.awready, 1'b0);
      @(negedge clk);
      check_eq("awready_first_edge", axi.awready, 1'b1);

      run_burst(1'b1, 12'h010, 8'd3, 3'd2, 2'b01, 3, 0, 1'b1);
      if (got_q.size() == 4) check_eq("t1_last_addr", got_q[3].addr, 10'd7);
      run_burst(1'b0, 12'h020, 8'd2, 3'd2, 2'b00, 2, 0, 1'b1);
      if (got_q.size() == 3) check_eq("t2_fixed_addr", got_q[2].addr, 10'd8);
      run_burst(1'b1, 12'h1FC, 8'd1, 3'd2, 2'b01, 1, 0, 1'b1);
      check_eq("t3_one_write", got_q.size(), 1);
      run_burst(1'b0, 12'h040, 8'd3, 3'd2, 2'b10, 3, 0, 1'b1);
      check_eq("t4_wrap_no_write", got_q.size(), 0);
      run_burst(1'b1, 12'h040, 8'd3, 3'b001, 2'b01, 3, 0, 1'b1);
      check_eq("t4_size_no_write", got_q.size(), 0);
      run_burst(1'b1, 12'h000, 8'd3, 3'd2, 2'b01, 1, 0, 1'b1);
      check_eq("t5_early_writes", got_q.size(), 2);
      run_burst(1'b0, 12'h000, 8'd3, 3'd2, 2'b01, -1, 0, 1'b1);
      check_eq("t5_nolast_writes", got_q.size(), 4);
      run_burst(1'b1, 12'h100, 8'd1, 3'd2, 2'b01, 1, 5, 1'b1);

      rand_gaps = 1'b1;
      for (int n = 0; n < 40; n++) begin
         a  = ($urandom_range(0, 9) == 0) ? 12'(12'hFF0 + $urandom_range(0, 15))
                                          : 12'($urandom_range(0, 12'h23F));
         l  = 8'($urandom_range(0, 7));
         sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
         r  = int'($urandom_range(0, 7));
         bt = (r < 4) ? 2'b01 : (r < 6) ? 2'b00 : 2'(r - 4);
         r  = int'($urandom_range(0, 5));
         la = (r == 0) ? -1 : (r == 1 && l > 0) ? int'($urandom_range(0, int'(l) - 1)) : int'(l);
         run_burst(1'($urandom), a, l, sz, bt, la, int'($urandom_range(0, 3)), 1'b0);
      end
      rand_gaps = 1'b0;

      // abort a burst mid-DATA with reset
      @(posedge clk); #1;
      axi.awid = 1'b1; axi.awaddr = 12'h000; axi.awlen = 8'd7; axi.awsize = 3'd2;
      axi.awburst = 2'b01; axi.awvalid = 1'b1;
      hs = 1'b0;
      for (int t = 0; t < 20 && !hs; t++) begin
         @(negedge clk); hs = axi.awready;
         @(posedge clk); #1;
      end
      axi.awvalid = 1'b0;
      check_eq("rst_aw_hs", hs, 1'b1);
      axi.wvalid = 1'b1; axi.wdata = 32'hDEAD_BEEF; axi.wstrb = 4'hF; axi.wlast = 1'b0;
      beats = 0;
      for (int t = 0; t < 20 && beats < 2; t++) begin
         @(negedge clk); if (axi.wready) beats++;
         @(posedge clk); #1;
      end
      check_eq("rst_pre_we", mem_we, 1'b1);
      rst = 1'b1;
      #1 check_idle("rst_async_drop");
      axi.wvalid = 1'b0;
      @(posedge clk); #1 check_idle("rst_held");
      @(negedge clk); rst = 1'b0;
      #1 check_eq("rst_awready_release", axi.awready, 1'b0);
      @(negedge clk);
      check_eq("rst_awready_edge", {axi.awready, axi.bvalid, axi.wready, busy}, 4'b1000);
      repeat (3) begin
         @(negedge clk);
         check_eq("rst_no_b", {axi.bvalid, mem_we}, 2'b00);
      end

      run_burst(1'b1, 12'h008, 8'd2, 3'd2, 2'b01, 2, 1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/conv_axi_full_wr_slave.md
Name: conv_axi_full_wr_slave

Overview:
- AXI4-Full write-channel slave on the s01 port of the convolution accelerator.
- Accepts INCR/FIXED write bursts from the PS/testbench master and turns each accepted beat into a single-word write strobe.
- The strobe drives the image/kernel buffer memory, which feeds the convolution core.
- No read channel (handled by a separate block); no outstanding-transaction overlap.

Parameters:
C_S01_AXI_ID_WIDTH, 1, width of AWID/BID
C_S01_AXI_DATA_WIDTH, 32, data width; only 32 supported
C_S01_AXI_ADDR_WIDTH, 12, byte address width
MEM_DEPTH, 128, buffer depth in 32-bit words; word index >= MEM_DEPTH is out of range

Ports:
s01_axi_aclk  in  1  clock
s01_axi_areset  in  1  reset, asynchronous, active-high
s01_axi_awid  in  C_S01_AXI_ID_WIDTH  write ID
s01_axi_awaddr  in  C_S01_AXI_ADDR_WIDTH  byte start address
s01_axi_awlen  in  8  beats minus 1
s01_axi_awsize  in  3  beat size; 3'b010 legal only
s01_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s01_axi_awvalid  in  1  AW valid
s01_axi_awready  out  1  AW ready
s01_axi_wdata  in  32  write data
s01_axi_wstrb  in  4  byte enables
s01_axi_wlast  in  1  last beat
s01_axi_wvalid  in  1  W valid
s01_axi_wready  out  1  W ready
s01_axi_bid  out  C_S01_AXI_ID_WIDTH  response ID
s01_axi_bresp  out  2  00 OKAY, 10 SLVERR
s01_axi_bvalid  out  1  B valid
s01_axi_bready  in  1  B ready
mem_we  out  1  buffer write enable
mem_addr  out  C_S01_AXI_ADDR_WIDTH-2  word address
mem_wdata  out  32  write data
mem_be  out  4  byte enables (= wstrb)
busy  out  1  high when state != IDLE

Behaviour:
- Clock and reset: one clock, s01_axi_aclk. s01_axi_areset is asynchronous and active-high.
- Reset values: all outputs are registered and reset to 0, including awready, wready, bvalid, bresp, bid, mem_*, busy. awready rises on the first clock edge after reset release.
- FSM states: IDLE, DATA, RESP.
- IDLE:
  - awready=1, wready=0, bvalid=0.
  - On awvalid & awready: latch awid, word pointer = awaddr[ADDR_W-1:2], awlen, awburst; clear beat counter.
  - Set err = (awsize != 3'b010) or awburst in {WRAP, reserved}.
  - Next: DATA with awready=0 and wready=1 on the following cycle.
  - W traffic arriving while in IDLE is not accepted.
- DATA:
  - wready=1; one beat is accepted per cycle while wvalid=1.
  - Per accepted beat: if !err and pointer < MEM_DEPTH, assert mem_we=1 on the next cycle for exactly one cycle, with mem_addr=pointer, mem_wdata=wdata, mem_be=wstrb.
  - If pointer >= MEM_DEPTH: suppress the write and set err (sticky).
  - Pointer update: INCR increments the pointer, wrapping mod 2^(ADDR_W-2); a wrap also sets err. FIXED holds the pointer.
  - Burst end when count == awlen: if wlast=0, set err. Next: RESP; wready=0 from the next cycle.
  - Early wlast (wlast=1 with count < awlen): set err and end the burst immediately.
  - The last beat's write is still performed if it is legal.
- RESP:
  - bvalid=1, bid=latched ID, bresp = err ? 10 : 00.
  - bvalid, bid and bresp hold stable until bready.
  - On bvalid & bready: IDLE; awready=1 on the next cycle.
- Latency:
  - AW handshake at cycle N gives wready=1 at N+1.
  - Beat handshake at cycle M gives mem_we at M+1.
  - Last beat at cycle L gives bvalid at L+1.
  - Minimum transaction is awlen+4 cycles, IDLE to IDLE.
- Memory errors: SLVERR does not roll back writes already issued for legal beats.
- Reset mid-transaction:
  - All outputs drop immediately (async); the burst is aborted and no B response is issued.
  - Any mem_we pending for the next cycle is discarded.
- Ignored AXI signals: the other AXI4 AW/W attributes (lock, cache, prot, qos, region, user) are not ports of this block; the top level leaves them unconnected.

Test Plan:
1. INCR, awaddr=0x010, awlen=3, awid=1, wdata 0x11,0x22,0x33,0x44, wstrb=F -> mem_we on 4 consecutive cycles at mem_addr 4,5,6,7 with matching data; bresp=00, bid=1.
2. FIXED, awaddr=0x020, awlen=2, data A,B,C -> three writes all at mem_addr 8 in the order A,B,C; bresp=00.
3. INCR, awaddr=0x1FC, awlen=1 -> word 127 written; word 128 suppressed (1 mem_we total); bresp=10.
4. WRAP, awlen=3 (also repeat with awsize=3'b001) -> 4 beats accepted, 0 mem_we; bresp=10.
5. INCR, awlen=3, wlast on beat 1 -> 2 writes; bvalid the cycle after beat 1; bresp=10. Repeat with wlast missing on beat 3 -> 4 writes; bresp=10.
6. bready held 0 for 5 cycles -> bvalid/bid/bresp stable and awready=0 throughout. Then assert reset in DATA after 2 beats -> all outputs 0 immediately, no B response, awready=1 one edge after release.
